screen_fill_arbiter: RTL and testbench
======================================

# screen_fill_arbiter

Hardware rectangle-fill engine for the Hack screen buffer (0x4000–0x5FFF, 32 words/row, 256 rows) that shares the CPU port of the dual-port video RAM with the CPU. It sits between the CPU and RAM port 1. While it owns the port it stalls the CPU, and it hands the port back between bursts. The VGA read port is untouched.

## Interface
Parameters:
- SCREEN_BASE, 15'h4000, word address of screen row 0, column 0
- BURST, 8, maximum consecutive engine writes before the port is released (1..32)

Ports:
- i_clk  in  1  system clock (CPU clock domain)
- i_rst  in  1  reset; one clock, synchronous, active-low
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1
- i_row0  in  8  first row, 0..255
- i_nrows  in  9  row count, 0..256
- i_col0  in  5  first word column, 0..31
- i_ncols  in  6  word-column count, 0..32
- i_pattern  in  16  fill word
- o_busy  out  1  fill in progress
- o_done  out  1  one-cycle completion pulse
- i_cpu_addr  in  15  CPU address to RAM port 1
- i_cpu_data  in  16  CPU write data
- i_cpu_write  in  1  CPU write enable
- o_stall  out  1  CPU must hold state; high exactly while the engine owns the port
- o_ram_addr  out  15  to RAM port-1 address
- o_ram_data  out  16  to RAM port-1 write data
- o_ram_write  out  1  to RAM port-1 write enable

## Operation
- States: IDLE, ARM, FILL, DONE. Registered owner bit: 1 in FILL, 0 otherwise; o_stall = owner.
- Port mux (combinational from owner):
  - owner=0: o_ram_* = i_cpu_*.
  - owner=1: o_ram_addr = engine address, o_ram_data = i_pattern latched at start, o_ram_write = 1.
- Start handling:
  - IDLE with i_start: latch parameters and apply clipping.
  - Clipping: effective rows = min(i_nrows, 256-i_row0); effective cols = min(i_ncols, 32-i_col0). No wrap-around.
  - If either effective count is 0, go to DONE. Otherwise go to ARM.
- ARM: if i_cpu_write=0, go to FILL. Otherwise stay in ARM. A CPU write is never pre-empted.
- FILL:
  - One write per cycle, address = SCREEN_BASE + row*32 + col, row-major order (col increments, then row).
  - Address arithmetic is 15-bit; the maximum result is 0x5FFF.
  - After BURST writes, or after the final write, leave FILL: to ARM if words remain, else to DONE.
  - The burst counter resets on each entry to FILL.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in ARM and FILL, 0 in IDLE and DONE.
- i_start arriving in DONE is ignored.
- Reset mid-operation: the next cycle is IDLE with owner=0 and no further engine writes. Words already written stay written.
- Reset values: o_busy=0, o_done=0, o_stall=0. o_ram_* follow i_cpu_* (passthrough).

## Timing
- Start sampled at cycle 0. First possible ARM cycle is 1 and first write is cycle 2.
- With no CPU writes, N words take N FILL cycles plus ceil(N/BURST) ARM cycles. The last write is at cycle N + ceil(N/BURST); o_done is high the next cycle.
- Each ARM cycle is a CPU slot with o_stall=0, so the CPU gets at least one access per BURST+1 cycles.
- o_stall changes only at clock edges, together with the owner.
- o_ram_write follows i_cpu_write combinationally when owner=0.
- Zero-size request: o_done at cycle 1, no writes, o_stall never asserted.

## Test plan
- Full screen, BURST=8: start(row0=0, nrows=256, col0=0, ncols=32, pattern=16'hFFFF) with CPU idle -> 8192 writes covering 0x4000..0x5FFF. o_stall is low at cycles 1, 10, 19, …. Last write at cycle 9216, o_done at 9217.
- Clipped rectangle: row0=10, nrows=2, col0=30, ncols=4, pattern=16'hA5A5 -> writes exactly 0x415E, 0x415F, 0x417E, 0x417F in that order, then o_done.
- CPU write contention: hold i_cpu_write=1 for cycles 1..5 after start -> engine stays in ARM and the CPU writes pass through unchanged. First engine write at cycle 7.
- Zero size: nrows=0 (and separately ncols=0) -> o_done at cycle 1, o_stall and o_busy stay 0, no engine writes.
- Reset mid-fill: assert i_rst=0 at the 5th write -> o_stall=0 and o_busy=0 next cycle, no further writes, no o_done. A new start afterwards completes normally.
- Start while busy: second i_start during FILL with a different pattern -> ignored. The original rectangle and pattern complete, with a single o_done.

Source files
------------

// File: rtl/screen_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : screen_fill_arbiter_if
// Description : Bundle of the fill-request, CPU-side and RAM port-1 signals
//               of the screen fill arbiter. The master modport is the
//               engine's view; the slave modport is the view of whoever
//               drives the requests and the CPU bus and receives the RAM
//               port.
// Revision    : 1.0 - initial release
// ============================================================================
interface screen_fill_arbiter_if;

    // Fill request and status
    logic        i_start;
    logic [7:0]  i_row0;
    logic [8:0]  i_nrows;
    logic [4:0]  i_col0;
    logic [5:0]  i_ncols;
    logic [15:0] i_pattern;
    logic        o_busy;
    logic        o_done;

    // CPU side of RAM port 1
    logic [14:0] i_cpu_addr;
    logic [15:0] i_cpu_data;
    logic        i_cpu_write;
    logic        o_stall;

    // RAM port 1
    logic [14:0] o_ram_addr;
    logic [15:0] o_ram_data;
    logic        o_ram_write;

    modport master (
        input  i_start, i_row0, i_nrows, i_col0, i_ncols, i_pattern,
        input  i_cpu_addr, i_cpu_data, i_cpu_write,
        output o_busy, o_done, o_stall,
        output o_ram_addr, o_ram_data, o_ram_write
    );

    modport slave (
        output i_start, i_row0, i_nrows, i_col0, i_ncols, i_pattern,
        output i_cpu_addr, i_cpu_data, i_cpu_write,
        input  o_busy, o_done, o_stall,
        input  o_ram_addr, o_ram_data, o_ram_write
    );

endinterface
`default_nettype wire

// File: rtl/screen_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : screen_fill_arbiter
// Description : Rectangle-fill engine for the Hack screen buffer. Shares RAM
//               port 1 with the CPU: while it owns the port it stalls the
//               CPU and writes one word per cycle, releasing the port for
//               one CPU slot after every BURST writes.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_fill_arbiter #(
    parameter logic [14:0] SCREEN_BASE = 15'h4000,
    parameter int          BURST       = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    screen_fill_arbiter_if.master bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Burst counter holds the index of the current write inside a burst
    localparam logic [5:0] c_BURST_LAST = 6'(BURST - 1);

    logic [1:0]  r_state;
    logic        r_owner;
    logic [7:0]  r_row;
    logic [7:0]  r_row_last;
    logic [4:0]  r_col;
    logic [4:0]  r_col0;
    logic [4:0]  r_col_last;
    logic [5:0]  r_burst;
    logic [15:0] r_pattern;

    logic [8:0]  w_row_room;
    logic [8:0]  w_rows_eff;
    logic [5:0]  w_col_room;
    logic [5:0]  w_cols_eff;
    logic        w_empty;
    logic [7:0]  w_row_last;
    logic [4:0]  w_col_last;
    logic        w_row_end;
    logic        w_last_word;
    logic        w_burst_end;
    logic [14:0] w_eng_addr;

    // Clip the request to the screen edges; rectangles never wrap
    always_comb begin
        w_row_room = 9'd256 - {1'b0, bus.i_row0};
        w_rows_eff = (bus.i_nrows < w_row_room) ? bus.i_nrows : w_row_room;
        w_col_room = 6'd32 - {1'b0, bus.i_col0};
        w_cols_eff = (bus.i_ncols < w_col_room) ? bus.i_ncols : w_col_room;
        w_empty    = (w_rows_eff == 9'd0) || (w_cols_eff == 6'd0);
        // Inclusive end coordinates; only meaningful when the rectangle is non-empty
        w_row_last = bus.i_row0 + 8'(w_rows_eff - 9'd1);
        w_col_last = bus.i_col0 + 5'(w_cols_eff - 6'd1);
    end

    // Walk position and burst bookkeeping derived from the current word
    always_comb begin
        w_row_end   = (r_col == r_col_last);
        w_last_word = w_row_end && (r_row == r_row_last);
        w_burst_end = (r_burst == c_BURST_LAST);
        w_eng_addr  = SCREEN_BASE + {2'b00, r_row, r_col};
    end

    // Control FSM and port ownership; ownership is held exactly in FILL
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= c_IDLE;
            r_owner <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= w_empty ? c_DONE : c_ARM;
                    end
                end
                c_ARM: begin
                    // A pending CPU write always completes before the engine takes over
                    if (!bus.i_cpu_write) begin
                        r_state <= c_FILL;
                        r_owner <= 1'b1;
                    end
                end
                c_FILL: begin
                    if (w_last_word) begin
                        r_state <= c_DONE;
                        r_owner <= 1'b0;
                    end else if (w_burst_end) begin
                        r_state <= c_ARM;
                        r_owner <= 1'b0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_owner <= 1'b0;
                end
            endcase
        end
    end

    // Request latch and row-major address walk
    always_ff @(posedge i_clk) begin
        case (r_state)
            c_IDLE: begin
                if (bus.i_start) begin
                    r_row      <= bus.i_row0;
                    r_col      <= bus.i_col0;
                    r_col0     <= bus.i_col0;
                    r_row_last <= w_row_last;
                    r_col_last <= w_col_last;
                    r_pattern  <= bus.i_pattern;
                end
            end
            c_ARM: begin
                r_burst <= 6'd0;
            end
            c_FILL: begin
                r_burst <= r_burst + 6'd1;
                if (w_row_end) begin
                    r_col <= r_col0;
                    r_row <= r_row + 8'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Port mux: CPU passes straight through unless the engine owns the port
    always_comb begin
        bus.o_ram_addr  = bus.i_cpu_addr;
        bus.o_ram_data  = bus.i_cpu_data;
        bus.o_ram_write = bus.i_cpu_write;
        if (r_owner) begin
            bus.o_ram_addr  = w_eng_addr;
            bus.o_ram_data  = r_pattern;
            bus.o_ram_write = 1'b1;
        end
    end

    assign bus.o_stall = r_owner;
    assign bus.o_busy  = (r_state == c_ARM) || (r_state == c_FILL);
    assign bus.o_done  = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_screen_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_fill_arbiter
// Description : Directed self-checking bench for screen_fill_arbiter with a
//               transaction-level reference model of the fill behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_fill_arbiter;

    localparam int BURST = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    screen_fill_arbiter_if bus ();

    screen_fill_arbiter #(
        .SCREEN_BASE (15'h4000),
        .BURST       (BURST)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: expected engine words and port ownership
    bit          m_own  = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_run  = 0;
    logic [15:0] m_pat  = 16'h0;
    logic [14:0] m_q[$];
    int          m_nr;
    int          m_nc;

    // Observation log relative to the latest start
    int          t0 = 0;
    int          rel;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_rel = -1;
    int          first_wr_rel = -1;
    int          last_wr_rel = -1;
    logic [14:0] wr_log[$];
    logic [31:0] stall_lo = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare DUT against the model every cycle, then advance the model
    initial forever begin
        @(negedge clk);
        rel = cyc - t0;
        check("o_stall", {31'h0, bus.o_stall}, {31'h0, m_own});
        check("o_busy",  {31'h0, bus.o_busy},  {31'h0, m_busy});
        check("o_done",  {31'h0, bus.o_done},  {31'h0, m_done});
        if (m_own) begin
            check("eng_write", {31'h0, bus.o_ram_write}, 32'h1);
            check("eng_addr",  {17'h0, bus.o_ram_addr},
                  {17'h0, (m_q.size() > 0) ? m_q[0] : 15'h7FFF});
            check("eng_data",  {16'h0, bus.o_ram_data}, {16'h0, m_pat});
        end else begin
            check("pass_write", {31'h0, bus.o_ram_write}, {31'h0, bus.i_cpu_write});
            check("pass_addr",  {17'h0, bus.o_ram_addr},  {17'h0, bus.i_cpu_addr});
            check("pass_data",  {16'h0, bus.o_ram_data},  {16'h0, bus.i_cpu_data});
        end

        if (bus.o_stall && bus.o_ram_write) begin
            if (wr_cnt == 0) first_wr_rel = rel;
            wr_cnt++;
            last_wr_rel = rel;
            wr_log.push_back(bus.o_ram_addr);
        end
        if (bus.o_done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (rel >= 0 && rel < 32 && !bus.o_stall) stall_lo[rel] = 1'b1;

        if (!rst_n) begin
            m_own = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_q.delete();
        end else if (m_own) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            m_run++;
            if (m_q.size() == 0) begin
                m_own = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end else if (m_run == BURST) begin
                m_own = 1'b0;
            end
        end else if (m_busy) begin
            if (!bus.i_cpu_write) begin
                m_own = 1'b1;
                m_run = 0;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (bus.i_start) begin
            m_nr = int'(bus.i_nrows);
            if (m_nr > 256 - int'(bus.i_row0)) m_nr = 256 - int'(bus.i_row0);
            m_nc = int'(bus.i_ncols);
            if (m_nc > 32 - int'(bus.i_col0)) m_nc = 32 - int'(bus.i_col0);
            for (int r = 0; r < m_nr; r++)
                for (int c = 0; c < m_nc; c++)
                    m_q.push_back(15'(32'h4000 + (int'(bus.i_row0) + r) * 32 + int'(bus.i_col0) + c));
            m_pat = bus.i_pattern;
            if (m_q.size() == 0) m_done = 1'b1;
            else m_busy = 1'b1;
        end
    end

    task automatic start_fill(input logic [7:0] r0, input logic [8:0] nr, input logic [4:0] c0,
                              input logic [5:0] nc, input logic [15:0] pat, input int hold);
        @(posedge clk); #1;
        bus.i_row0 = r0; bus.i_nrows = nr; bus.i_col0 = c0; bus.i_ncols = nc;
        bus.i_pattern = pat; bus.i_start = 1'b1;
        t0 = cyc; wr_cnt = 0; done_cnt = 0; done_rel = -1;
        first_wr_rel = -1; last_wr_rel = -1; wr_log.delete(); stall_lo = 32'h0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no o_done in %0d cycles expected one", name, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < wr_log.size()) ? {17'h0, wr_log[i]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int k;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_row0 = 8'd0; bus.i_nrows = 9'd0;
        bus.i_col0 = 5'd0; bus.i_ncols = 6'd0; bus.i_pattern = 16'h0;
        bus.i_cpu_addr = 15'h1234; bus.i_cpu_data = 16'hBEEF; bus.i_cpu_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'h0, bus.o_busy},  32'h0);
        check("rst_done",  {31'h0, bus.o_done},  32'h0);
        check("rst_stall", {31'h0, bus.o_stall}, 32'h0);
        check("rst_addr",  {17'h0, bus.o_ram_addr}, 32'h1234);
        rst_n = 1'b1;

        // Clipped rectangle at the right edge
        start_fill(8'd10, 9'd2, 5'd30, 6'd4, 16'hA5A5, 1);
        wait_done(100, "clip");
        check("clip_count", wr_cnt, 4);
        check("clip_a0", log_at(0), 32'h415E);
        check("clip_a1", log_at(1), 32'h415F);
        check("clip_a2", log_at(2), 32'h417E);
        check("clip_a3", log_at(3), 32'h417F);
        check("clip_first", first_wr_rel, 2);
        check("clip_done_rel", done_rel, 6);

        // Zero rows; start held into the DONE cycle must be ignored
        start_fill(8'd5, 9'd0, 5'd3, 6'd4, 16'h1111, 2);
        wait_done(20, "zero_rows");
        check("zr_done_rel", done_rel, 1);
        check("zr_writes", wr_cnt, 0);
        check("zr_done_cnt", done_cnt, 1);

        // Zero columns
        start_fill(8'd5, 9'd3, 5'd3, 6'd0, 16'h2222, 1);
        wait_done(20, "zero_cols");
        check("zc_done_rel", done_rel, 1);
        check("zc_writes", wr_cnt, 0);

        // CPU writes in cycles 1..5 hold the engine in its arm slot
        start_fill(8'd0, 9'd1, 5'd0, 6'd3, 16'h5A5A, 1);
        for (int i = 1; i <= 5; i++) begin
            bus.i_cpu_write = 1'b1;
            bus.i_cpu_addr  = 15'(15'h0100 + i);
            bus.i_cpu_data  = 16'(16'hD000 + i);
            @(posedge clk); #1;
        end
        bus.i_cpu_write = 1'b0;
        bus.i_cpu_addr  = 15'h1234;
        bus.i_cpu_data  = 16'hBEEF;
        wait_done(50, "contention");
        check("ct_first", first_wr_rel, 7);
        check("ct_count", wr_cnt, 3);
        check("ct_done_rel", done_rel, 10);

        // Bottom-right clip spanning multiple bursts
        start_fill(8'd254, 9'd5, 5'd22, 6'd10, 16'h3C3C, 1);
        wait_done(100, "corner");
        check("cn_count", wr_cnt, 20);
        check("cn_first_addr", log_at(0), 32'h5FD6);
        check("cn_last_addr", log_at(19), 32'h5FFF);
        check("cn_done_rel", done_rel, 24);
        check("cn_stall_lo", stall_lo & 32'h000F_FFFF, 32'h0008_0403);

        // Second start during FILL is ignored
        start_fill(8'd100, 9'd3, 5'd0, 6'd8, 16'hC3C3, 1);
        repeat (3) @(posedge clk);
        #1;
        bus.i_start = 1'b1; bus.i_pattern = 16'h0F0F; bus.i_row0 = 8'd7;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        wait_done(100, "busy_start");
        repeat (30) @(posedge clk);
        #1;
        check("bs_count", wr_cnt, 24);
        check("bs_done_cnt", done_cnt, 1);
        check("bs_done_rel", done_rel, 28);
        bus.i_pattern = 16'h0;

        // Reset during the fifth engine write
        start_fill(8'd0, 9'd2, 5'd0, 6'd32, 16'h7777, 1);
        k = 0;
        while (!(wr_cnt == 4 && bus.o_stall) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("rm_reached", {31'h0, bus.o_stall}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rm_stall", {31'h0, bus.o_stall}, 32'h0);
        check("rm_busy",  {31'h0, bus.o_busy},  32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("rm_writes", wr_cnt, 5);
        check("rm_no_done", done_cnt, 0);
        start_fill(8'd1, 9'd1, 5'd0, 6'd2, 16'h4242, 1);
        wait_done(50, "after_reset");
        check("ar_count", wr_cnt, 2);
        check("ar_done_rel", done_rel, 4);

        // Full screen
        start_fill(8'd0, 9'd256, 5'd0, 6'd32, 16'hFFFF, 1);
        wait_done(10000, "full");
        check("fs_count", wr_cnt, 8192);
        check("fs_first_addr", log_at(0), 32'h4000);
        check("fs_last_addr", log_at(8191), 32'h5FFF);
        check("fs_last_wr", last_wr_rel, 9216);
        check("fs_done_rel", done_rel, 9217);
        check("fs_stall_lo", stall_lo & 32'h000F_FFFF, 32'h0008_0403);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
